// File: rtl/sram_banked.sv
// sram_banked: multi-bank scratchpad with one write port and one read port.
// Words are interleaved across banks on the low address bits. A read that
// targets the bank being written in the same cycle is refused and counted.
// Read data leaves through an output register plus RD_LAT-1 pipeline stages.
module sram_banked #(
  parameter int DEPTH     = 2048,
  parameter int DATA_W    = 32,
  parameter int NUM_BANKS = 4,
  parameter int RD_LAT    = 1,
  parameter int CNT_W     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  W_CEN,
  input  logic [ADDR_W-1:0]     W_A,
  input  logic [DATA_W-1:0]     W_D,
  input  logic [DATA_W/8-1:0]   W_BEN,
  input  logic                  R_CEN,
  input  logic [ADDR_W-1:0]     R_A,
  output logic                  R_RDY,
  output logic [DATA_W-1:0]     Q,
  output logic                  Q_VALID,
  output logic [CNT_W-1:0]      CONF_CNT
);

  localparam int ROWS   = DEPTH / NUM_BANKS;
  localparam int ROW_W  = ADDR_W - BANK_W;
  localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;
  localparam int NBYTES = DATA_W / 8;

  logic [SEL_W-1:0]  w_bank;
  logic [SEL_W-1:0]  r_bank;
  logic [ROW_W-1:0]  w_row;
  logic [ROW_W-1:0]  r_row;
  logic              w_en;
  logic              r_req;
  logic              conflict;
  logic              rd_accept;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_W-1:0] pipe_d [RD_LAT];
  logic [RD_LAT-1:0] pipe_v;
  logic [CNT_W-1:0]  conf_cnt;

  // With a single bank there are no select bits; everything maps to bank 0.
  if (BANK_W == 0) begin : g_one_bank
    assign w_bank = '0;
    assign r_bank = '0;
  end else begin : g_multi_bank
    assign w_bank = W_A[BANK_W-1:0];
    assign r_bank = R_A[BANK_W-1:0];
  end

  assign w_row = W_A[ADDR_W-1:BANK_W];
  assign r_row = R_A[ADDR_W-1:BANK_W];

  assign w_en      = !W_CEN;
  assign r_req     = !R_CEN;
  assign conflict  = r_req && w_en && (r_bank == w_bank);
  assign R_RDY     = !conflict;
  assign rd_accept = r_req && !conflict;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];

    // Byte-masked write into this bank; contents are never reset.
    always_ff @(posedge CLK) begin
      if (w_en && (w_bank == SEL_W'(b))) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (W_BEN[i]) begin
            mem[w_row][8*i +: 8] <= W_D[8*i +: 8];
          end
        end
      end
    end

    assign bank_rdata[b] = mem[r_row];
  end

  // Output register captures the addressed word on accept, then the valid
  // strobe and data shift through the remaining stages; data only moves with
  // a valid so the final stage holds its last result between reads.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pipe_v <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_d[s] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) begin
        pipe_d[0] <= bank_rdata[r_bank];
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        if (pipe_v[s-1]) begin
          pipe_d[s] <= pipe_d[s-1];
        end
      end
    end
  end

  assign Q       = pipe_d[RD_LAT-1];
  assign Q_VALID = pipe_v[RD_LAT-1];

  // Saturating count of cycles in which a read request was refused.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      conf_cnt <= '0;
    end else if (r_req && conflict && (conf_cnt != {CNT_W{1'b1}})) begin
      conf_cnt <= conf_cnt + CNT_W'(1);
    end
  end

  assign CONF_CNT = conf_cnt;

endmodule

// File: tb/tb_sram_banked.sv
// tb_sram_banked: drives two instances (read latency 1 and 3) with the same
// directed vectors and checks them against a flat-memory reference model.
module tb_sram_banked;

  localparam int DEPTH = 2048;
  localparam int NB    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_cen;
  logic [10:0] w_a;
  logic [31:0] w_d;
  logic [3:0]  w_ben;
  logic        r_cen;
  logic [10:0] r_a;

  logic        rdy1, qv1, rdy3, qv3;
  logic [31:0] q1, q3;
  logic [15:0] cnt1, cnt3;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  sram_banked #(.DEPTH(DEPTH), .DATA_W(32), .NUM_BANKS(NB), .RD_LAT(1), .CNT_W(16)) u_dut_lat1 (
    .CLK(clk), .RSTN(rst_n), .W_CEN(w_cen), .W_A(w_a), .W_D(w_d), .W_BEN(w_ben),
    .R_CEN(r_cen), .R_A(r_a), .R_RDY(rdy1), .Q(q1), .Q_VALID(qv1), .CONF_CNT(cnt1)
  );

  sram_banked #(.DEPTH(DEPTH), .DATA_W(32), .NUM_BANKS(NB), .RD_LAT(3), .CNT_W(16)) u_dut_lat3 (
    .CLK(clk), .RSTN(rst_n), .W_CEN(w_cen), .W_A(w_a), .W_D(w_d), .W_BEN(w_ben),
    .R_CEN(r_cen), .R_A(r_a), .R_RDY(rdy3), .Q(q3), .Q_VALID(qv3), .CONF_CNT(cnt3)
  );

  always #5 clk = ~clk;

  // Reference model: flat memory, reads scheduled to complete at a due edge.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] model_mem [DEPTH];
  rd_t         pend1[$];
  rd_t         pend3[$];
  int          edge_no = 0;
  logic        exp_v1, exp_v3;
  logic [31:0] exp_q1, exp_q3;
  logic [15:0] exp_cnt;

  function automatic logic model_rdy();
    return !(!r_cen && !w_cen && ((r_a % NB) == (w_a % NB)));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic model_clear();
    pend1.delete();
    pend3.delete();
    exp_v1  = 1'b0;
    exp_v3  = 1'b0;
    exp_q1  = '0;
    exp_q3  = '0;
    exp_cnt = '0;
  endtask

  // Model update at every rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    rd_t r;
    edge_no++;
    if (rst_n) begin
      if (!r_cen && model_rdy()) begin
        r.data = model_mem[r_a];
        r.due  = edge_no;
        pend1.push_back(r);
        r.due  = edge_no + 2;
        pend3.push_back(r);
      end
      if (!r_cen && !model_rdy() && exp_cnt != 16'hFFFF) exp_cnt++;
    end
    if (!w_cen) begin
      for (int i = 0; i < 4; i++) begin
        if (w_ben[i]) model_mem[w_a][8*i +: 8] = w_d[8*i +: 8];
      end
    end
    if (rst_n) begin
      exp_v1 = 1'b0;
      if (pend1.size() > 0 && pend1[0].due == edge_no) begin
        exp_v1 = 1'b1;
        exp_q1 = pend1[0].data;
        void'(pend1.pop_front());
      end
      exp_v3 = 1'b0;
      if (pend3.size() > 0 && pend3[0].due == edge_no) begin
        exp_v3 = 1'b1;
        exp_q3 = pend3[0].data;
        void'(pend3.pop_front());
      end
    end else begin
      model_clear();
    end
  end

  // Asynchronous reset drops everything in flight immediately.
  always @(negedge rst_n) model_clear();

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rdy_lat1",  {31'b0, rdy1}, {31'b0, model_rdy()});
      checkOutput("rdy_lat3",  {31'b0, rdy3}, {31'b0, model_rdy()});
      checkOutput("qv_lat1",   {31'b0, qv1},  {31'b0, exp_v1});
      checkOutput("qv_lat3",   {31'b0, qv3},  {31'b0, exp_v3});
      checkOutput("q_lat1",    q1, exp_q1);
      checkOutput("q_lat3",    q3, exp_q3);
      checkOutput("cnt_lat1",  {16'b0, cnt1}, {16'b0, exp_cnt});
      checkOutput("cnt_lat3",  {16'b0, cnt3}, {16'b0, exp_cnt});
    end
  end

  task automatic applyStimulus(input logic wcen, input logic [10:0] wa, input logic [31:0] wd,
                               input logic [3:0] wben, input logic rcen, input logic [10:0] ra);
    @(posedge clk);
    #1;
    w_cen = wcen;
    w_a   = wa;
    w_d   = wd;
    w_ben = wben;
    r_cen = rcen;
    r_a   = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b1, 11'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_clear();
    rst_n = 1'b0;
    w_cen = 1'b1; w_a = '0; w_d = '0; w_ben = '0;
    r_cen = 1'b1; r_a = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checking = 1'b1;
    checkOutput("reset_qv1", {31'b0, qv1}, 32'd0);
    checkOutput("reset_q3", q3, 32'd0);
    checkOutput("reset_cnt", {16'b0, cnt1}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic write then read, latency 1, then Q hold
    applyStimulus(1'b0, 11'd5, 32'hDEADBEEF, 4'hF, 1'b1, 11'd0);
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd5);
    @(negedge clk);
    checkOutput("t1_rdy", {31'b0, rdy1}, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("t1_qv", {31'b0, qv1}, 32'd1);
    checkOutput("t1_q", q1, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    checkOutput("t1_hold_qv", {31'b0, qv1}, 32'd0);
    checkOutput("t1_hold_q", q1, 32'hDEADBEEF);

    // Byte-masked write
    applyStimulus(1'b0, 11'd8, 32'h11223344, 4'hF, 1'b1, 11'd0);
    applyStimulus(1'b0, 11'd8, 32'hAABBCCDD, 4'b0101, 1'b1, 11'd0);
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd8);
    idle();
    @(negedge clk);
    checkOutput("t2_mask_q", q1, 32'h11BB33DD);

    // Same-bank conflict, then retry without the write
    applyStimulus(1'b0, 11'd10, 32'hA0A0A0A0, 4'hF, 1'b1, 11'd0);
    applyStimulus(1'b0, 11'd6, 32'h06060606, 4'hF, 1'b0, 11'd10);
    @(negedge clk);
    checkOutput("t3_conf_rdy", {31'b0, rdy1}, 32'd0);
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd10);
    @(negedge clk);
    checkOutput("t3_cnt", {16'b0, cnt1}, 32'd1);
    checkOutput("t3_retry_rdy", {31'b0, rdy1}, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("t3_q", q1, 32'hA0A0A0A0);

    // Different banks at the same edge
    applyStimulus(1'b0, 11'd1, 32'h7, 4'hF, 1'b1, 11'd0);
    applyStimulus(1'b0, 11'd4, 32'h1, 4'hF, 1'b0, 11'd1);
    @(negedge clk);
    checkOutput("t4_rdy", {31'b0, rdy1}, 32'd1);
    idle();
    @(negedge clk);
    checkOutput("t4_q_old", q1, 32'h7);
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd4);
    idle();
    @(negedge clk);
    checkOutput("t4_q_new", q1, 32'h1);

    // Back-to-back reads through the 3-stage instance
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 11'(k), 32'(k), 4'hF, 1'b1, 11'd0);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'(k));
      else idle();
      @(negedge clk);
      checkOutput("t5_qv3", {31'b0, qv3}, (k >= 3 && k <= 10) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 10) checkOutput("t5_q3", q3, 32'(k - 3));
    end

    // Reset while two reads are in flight
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd2);
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    r_cen = 1'b1;
    #1;
    checkOutput("t6_rst_qv3", {31'b0, qv3}, 32'd0);
    checkOutput("t6_rst_q3", q3, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle();
      @(negedge clk);
      checkOutput("t6_no_valid", {31'b0, qv3}, 32'd0);
    end
    applyStimulus(1'b1, 11'd0, 32'd0, 4'h0, 1'b0, 11'd2);
    idle();
    @(negedge clk);
    checkOutput("t6_kept_q", q1, 32'd2);

    // Counter saturation under sustained conflicts
    for (int k = 0; k < 70000; k++) applyStimulus(1'b0, 11'd0, 32'h55550000, 4'hF, 1'b0, 11'd4);
    @(negedge clk);
    checkOutput("t7_sat", {16'b0, cnt1}, 32'h0000FFFF);
    idle();
    idle();
    @(negedge clk);
    checkOutput("t7_sat_hold", {16'b0, cnt3}, 32'h0000FFFF);

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_banked.md
Name: sram_banked

Overview:
- Parametrised, multi-bank successor to the single-port activation/weight SRAM.
- One write port and one read port are active in the same cycle.
- Address-interleaved banks, per-byte write enables, configurable read latency with a valid strobe, and same-bank conflict back-pressure on the read port.
- Sits between the L0/OFIFO datapath and the core controller as the shared scratchpad.

Parameters:
- DEPTH, 2048, total words across all banks (multiple of NUM_BANKS).
- DATA_W, 32, word width in bits (multiple of 8).
- NUM_BANKS, 4, bank count (power of 2, >=1).
- RD_LAT, 1, read latency in cycles from accepted request to Q_VALID (1..4).
- ADDR_W, $clog2(DEPTH), word address width (derived).
- BANK_W, $clog2(NUM_BANKS), bank-select width (derived; 0 when NUM_BANKS=1).
- CNT_W, 16, width of the conflict counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- W_CEN  input  1  write request, active-low.
- W_A  input  ADDR_W  write word address.
- W_D  input  DATA_W  write data.
- W_BEN  input  DATA_W/8  byte enables, active-high; bit i covers W_D[8i+7:8i].
- R_CEN  input  1  read request, active-low.
- R_A  input  ADDR_W  read word address.
- R_RDY  output  1  read request accepted this cycle (combinational).
- Q  output  DATA_W  read data.
- Q_VALID  output  1  Q carries the result of an accepted read.
- CONF_CNT  output  CNT_W  saturating count of cycles where a read was refused.

Behaviour:
- Bank mapping: bank = A[BANK_W-1:0], row = A[ADDR_W-1:BANK_W]. Each bank is DEPTH/NUM_BANKS rows.
- Write: when W_CEN=0, at the rising edge, bytes of mem[bank][row] with W_BEN[i]=1 take W_D; other bytes are unchanged. W_BEN=0 gives no change. Writes are never stalled.
- Read request:
  - R_RDY = !(R_CEN==0 && W_CEN==0 && R_A bank == W_A bank).
  - R_RDY is 1 whenever R_CEN=1.
  - A read is accepted when R_CEN=0 && R_RDY=1.
  - A refused requester holds R_A and R_CEN and retries; the block stores nothing for refused reads.
- Read data:
  - An accepted read at edge N samples mem[bank][row] as it stands before any write at edge N. A write to a different bank at the same edge is irrelevant to the result.
  - Q and Q_VALID=1 appear after edge N+RD_LAT-1, i.e. RD_LAT rising edges after the request cycle, counting edge N. With RD_LAT=1, Q is valid in the cycle after the request.
  - Pipeline: RD_LAT-1 register stages for data plus valid, after the array output register.
  - Full throughput: one accepted read per cycle, back-to-back.
- Q hold: when no accepted read completes, Q_VALID=0 and Q holds its last value.
- Read-after-write: a read of an address accepted in any cycle after the write edge returns the written bytes.
- Conflict counter: CONF_CNT increments by 1 on each edge where R_CEN=0 && R_RDY=0. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (RSTN=0, asynchronous, any time including mid-pipeline):
  - Q_VALID=0, Q=0, CONF_CNT=0, all valid-pipeline stages cleared; in-flight reads are dropped.
  - R_RDY follows its combinational rule and does not depend on reset.
  - Array contents are not reset and are preserved across reset.
  - Deassertion is synchronised by the integrator; the block needs no internal synchroniser.
- NUM_BANKS=1: every simultaneous read+write conflicts. R_RDY=0 whenever both ports request.
- Out-of-range addresses are impossible: DEPTH is a power of 2 by integration rule.

Test Plan:
- Reset, then W_CEN=0, W_A=5, W_D=32'hDEADBEEF, W_BEN=4'hF; next cycle R_CEN=0, R_A=5 -> R_RDY=1; with RD_LAT=1, next cycle Q_VALID=1, Q=32'hDEADBEEF; following idle cycle Q_VALID=0, Q unchanged.
- Byte mask: addr 8 holds 32'h11223344; write W_D=32'hAABBCCDD, W_BEN=4'b0101 -> read returns 32'h11BB33DD.
- Conflict: 4 banks; same-cycle write addr 6 and read addr 10 (both bank 2) -> R_RDY=0, CONF_CNT=1; hold one more cycle without write -> accepted; Q returns the freshly written addr-10 data only if addr 10 was written.
- No conflict, same edge: write addr 4 (bank 0) with 32'h1, read addr 1 (bank 1) holding 32'h7 -> R_RDY=1, Q=32'h7; then reading addr 4 returns 32'h1.
- RD_LAT=3, 8 back-to-back reads of addr 0..7 holding values 0..7 -> Q_VALID high for exactly 8 consecutive cycles starting 3 edges after the first request, Q=0..7 in order.
- Mid-pipeline reset: RD_LAT=3, issue 2 reads, assert RSTN=0 one cycle later -> Q_VALID=0 and Q=0 immediately, no valid pulse after release; earlier written data is still readable afterwards. Also force 70000 refused cycles with CNT_W=16 -> CONF_CNT=16'hFFFF.
